// File: rtl/gf_arith_unit_pkg.sv
// Shared definitions for the GF(2^M) arithmetic unit.
//   - operation encoding presented on the op input
//   - controller state encoding
//   - default symbol width and primitive polynomial (GF(2^8), x^8+x^4+x^3+x^2+1)
package gf_arith_unit_pkg;

   localparam int         GF_M_DEFAULT    = 8;
   localparam logic [8:0] GF_POLY_DEFAULT = 9'h11D;

   typedef enum logic [1:0] {
      GF_OP_ADD = 2'd0,
      GF_OP_MUL = 2'd1,
      GF_OP_INV = 2'd2,
      GF_OP_DIV = 2'd3
   } gf_op_e;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_ITER = 2'd1,
      ST_DONE = 2'd2
   } gf_state_e;

endpackage

// File: rtl/gf_arith_unit_if.sv
// Request/response bundle of the GF(2^M) arithmetic unit.
//   in_valid/in_ready : request handshake, carries op, a, b
//   out_valid/out_ready : response handshake, carries result, div_by_zero
// master = requester (drives the request and out_ready), slave = the unit.
interface gf_arith_unit_if #(
   parameter int M = 8
);
   logic         in_valid;
   logic         in_ready;
   logic [1:0]   op;
   logic [M-1:0] a;
   logic [M-1:0] b;
   logic         out_valid;
   logic         out_ready;
   logic [M-1:0] result;
   logic         div_by_zero;

   modport master (
      output in_valid, op, a, b, out_ready,
      input  in_ready, out_valid, result, div_by_zero
   );

   modport slave (
      input  in_valid, op, a, b, out_ready,
      output in_ready, out_valid, result, div_by_zero
   );
endinterface

// File: rtl/gf_arith_unit_mul_comb.sv
// gf_mul_comb: purely combinational GF(2^M) multiplier, polynomial basis.
//   i_a, i_b : operands (M bits)
//   o_p      : i_a * i_b reduced modulo POLY (M bits)
module gf_mul_comb #(
   parameter int         M    = 8,
   parameter logic [M:0] POLY = 9'h11D
) (
   input  logic [M-1:0] i_a,
   input  logic [M-1:0] i_b,
   output logic [M-1:0] o_p
);

   // Shift-and-add: the running multiple of i_a is multiplied by x each step
   // and reduced immediately, so no intermediate exceeds M bits.
   function automatic logic [M-1:0] gf_mul(input logic [M-1:0] x, input logic [M-1:0] y);
      logic [M-1:0] p;
      logic [M-1:0] t;
      logic         msb;
      p = '0;
      t = x;
      for (int i = 0; i < M; i++) begin
         if (y[i]) p = p ^ t;
         msb = t[M-1];
         t   = {t[M-2:0], 1'b0} ^ (msb ? POLY[M-1:0] : '0);
      end
      return p;
   endfunction

   assign o_p = gf_mul(i_a, i_b);

endmodule

// File: rtl/gf_arith_unit.sv
// gf_arith_unit: GF(2^M) ADD / MUL / INV / DIV with valid/ready handshakes.
//   clk   : clock, rising edge
//   reset : asynchronous, active-high
//   bus   : gf_arith_unit_if slave (request op/a/b, response result/div_by_zero)
// ADD and MUL complete on the accepting edge. INV and DIV use Fermat
// exponentiation, a/b = a * b^(2^M-2), evaluated by M-1 square-and-multiply
// steps, so no log/antilog tables are needed.
module gf_arith_unit
   import gf_arith_unit_pkg::*;
#(
   parameter int         M    = GF_M_DEFAULT,
   parameter logic [M:0] POLY = (M+1)'(GF_POLY_DEFAULT)
) (
   input  logic              clk,
   input  logic              reset,
   gf_arith_unit_if.slave    bus
);

   localparam int CW = $clog2(M) + 1;

   gf_state_e    r_state;
   gf_state_e    w_state_nxt;
   logic [M-1:0] r_sq;
   logic [M-1:0] r_acc;
   logic [CW-1:0] r_cnt;
   logic         r_dbz;

   gf_op_e       w_op;
   logic         w_accept;
   logic [M-1:0] w_m1_a;
   logic [M-1:0] w_m1_b;
   logic [M-1:0] w_m1_p;
   logic [M-1:0] w_m2_p;

   assign w_op     = gf_op_e'(bus.op);
   assign w_accept = bus.in_valid && (r_state == ST_IDLE);

   assign bus.in_ready    = (r_state == ST_IDLE);
   assign bus.out_valid   = (r_state == ST_DONE);
   assign bus.result      = r_acc;
   assign bus.div_by_zero = r_dbz;

   // The first multiplier serves MUL while idle and squares sq while iterating.
   assign w_m1_a = (r_state == ST_ITER) ? r_sq : bus.a;
   assign w_m1_b = (r_state == ST_ITER) ? r_sq : bus.b;

   gf_mul_comb #(.M(M), .POLY(POLY)) u_mul_sq (
      .i_a (w_m1_a),
      .i_b (w_m1_b),
      .o_p (w_m1_p)
   );

   gf_mul_comb #(.M(M), .POLY(POLY)) u_mul_acc (
      .i_a (r_acc),
      .i_b (w_m1_p),
      .o_p (w_m2_p)
   );

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         ST_IDLE: begin
            if (bus.in_valid) begin
               if (w_op == GF_OP_ADD || w_op == GF_OP_MUL) w_state_nxt = ST_DONE;
               else                                         w_state_nxt = ST_ITER;
            end
         end
         ST_ITER: begin
            if (r_cnt == CW'(1)) w_state_nxt = ST_DONE;
         end
         ST_DONE: begin
            if (bus.out_ready) w_state_nxt = ST_IDLE;
         end
         default: w_state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state <= ST_IDLE;
         r_sq    <= '0;
         r_acc   <= '0;
         r_cnt   <= '0;
         r_dbz   <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         if (w_accept) begin
            case (w_op)
               GF_OP_ADD: begin
                  r_acc <= bus.a ^ bus.b;
                  r_dbz <= 1'b0;
               end
               GF_OP_MUL: begin
                  r_acc <= w_m1_p;
                  r_dbz <= 1'b0;
               end
               default: begin
                  // INV is DIV with an implicit dividend of 1.
                  r_sq  <= bus.b;
                  r_acc <= (w_op == GF_OP_DIV) ? bus.a : M'(1);
                  r_cnt <= CW'(M - 1);
                  r_dbz <= (bus.b == '0);
               end
            endcase
         end else if (r_state == ST_ITER) begin
            // sq walks b^2, b^4, ... ; acc collects their product.
            r_sq  <= w_m1_p;
            r_acc <= w_m2_p;
            r_cnt <= r_cnt - CW'(1);
         end
      end
   end

endmodule
